seqgen_tx: RTL and testbench

Serial pattern transmitter: accepts a parallel pattern word over a valid/ready load handshake and shifts it out MSB-first on a one-bit serial line `x`, optionally repeating the frame with idle gaps. It is the stimulus-side counterpart of the team's serial sequence detectors. Its `x` output drives a detector's `x` input directly, on the same `clk`.

---
 rtl/seqgen_pkg.sv | 26 ++
 rtl/seqgen_piso.sv | 40 ++++
 rtl/seqgen_tx.sv | 129 ++++++++++++
 tb/tb_seqgen_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seqgen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seqgen_pkg
// Purpose  : Shared definitions for the serial pattern transmitter:
//            default parameter values, FSM state encoding and a width helper.
// Revision : 1.0 - initial release
// ============================================================================
package seqgen_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_REPEAT_W = 4;
  localparam int DEF_GAP      = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAPW  = 2'd2
  } state_e;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seqgen_piso.sv
`default_nettype none
// ============================================================================
// Module   : seqgen_piso
// Purpose  : WIDTH-bit parallel-in / serial-out register. Shifts left and
//            rotates the outgoing MSB back into bit 0, so after WIDTH shifts
//            the original word is restored (used for frame repeats).
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            i_load        - capture i_data (has priority over i_shift)
//            i_shift       - rotate left by one
//            i_data        - parallel word
//            o_msb         - current bit WIDTH-1
// Revision : 1.0 - initial release
// ============================================================================
module seqgen_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {r_sh[WIDTH-2:0], r_sh[WIDTH-1]};
    end
  end

  assign o_msb = r_sh[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/seqgen_tx.sv
`default_nettype none
// ============================================================================
// Module   : seqgen_tx
// Purpose  : Serial pattern transmitter. Accepts a pattern word over a
//            valid/ready handshake and sends it MSB-first on x, repeating the
//            frame load_count extra times with GAP idle cycles in between.
// Ports    : clk, rst                 - clock, asynchronous active-high reset
//            load_valid/load_ready    - pattern load handshake
//            load_data, load_count    - pattern and extra repetition count
//            abort                    - cancel the running transfer
//            x, x_valid               - serial bit and its qualifier
//            busy                     - transfer in progress
//            done                     - one-cycle pulse after the final bit
// Revision : 1.0 - initial release
// ============================================================================
module seqgen_tx
  import seqgen_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REPEAT_W = DEF_REPEAT_W,
  parameter int GAP      = DEF_GAP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [WIDTH-1:0]    load_data,
  input  logic [REPEAT_W-1:0] load_count,
  input  logic                abort,
  output logic                x,
  output logic                x_valid,
  output logic                busy,
  output logic                done
);

  localparam int c_BW = clog2_min1(WIDTH);
  localparam int c_GW = clog2_min1(GAP + 1);

  localparam logic [1:0] c_IDLE  = ST_IDLE;
  localparam logic [1:0] c_SHIFT = ST_SHIFT;
  localparam logic [1:0] c_GAPW  = ST_GAPW;

  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WIDTH - 1);
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]          r_state;
  logic [c_BW-1:0]     r_bit;
  logic [c_GW-1:0]     r_gap;
  logic [REPEAT_W-1:0] r_frame;
  logic                r_done;

  logic w_accept;
  logic w_shift;
  logic w_msb;

  assign w_accept = (r_state == c_IDLE) && load_valid;
  assign w_shift  = (r_state == c_SHIFT);

  seqgen_piso #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (load_data),
    .o_msb   (w_msb)
  );

  // Outputs are pure decodes of flops, so reset clears them immediately and
  // no input reaches an output without passing a register.
  assign x          = w_shift & w_msb;
  assign x_valid    = w_shift;
  assign busy       = (r_state == c_SHIFT) || (r_state == c_GAPW);
  assign load_ready = (r_state == c_IDLE);
  assign done       = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_bit   <= '0;
      r_gap   <= '0;
      r_frame <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (load_valid) begin
            r_frame <= load_count;
            r_bit   <= '0;
            r_gap   <= '0;
            r_state <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          if (abort) begin
            r_state <= c_IDLE;
          end else if (r_bit == c_BIT_LAST) begin
            r_bit <= '0;
            if (r_frame == '0) begin
              r_state <= c_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_frame <= r_frame - 1'b1;
              r_gap   <= '0;
              r_state <= (GAP > 0) ? c_GAPW : c_SHIFT;
            end
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        c_GAPW: begin
          if (abort) begin
            r_state <= c_IDLE;
          end else if (r_gap == c_GAP_LAST) begin
            r_gap   <= '0;
            r_state <= c_SHIFT;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seqgen_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seqgen_tx
// Purpose  : Self-checking bench for seqgen_tx. One instance with GAP=1 and
//            one with GAP=0 share the data/count/abort/reset stimulus; each
//            has its own load_valid. A small "101" detector watches the
//            GAP=1 instance's x output on the same clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seqgen_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       lv1, lv0;
  logic [7:0] ld_data;
  logic [3:0] ld_cnt;
  logic       abort;

  logic x1, xv1, busy1, done1, rdy1;
  logic x0, xv0, busy0, done0, rdy0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seqgen_tx #(.WIDTH(8), .REPEAT_W(4), .GAP(1)) dut (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(rdy1),
    .load_data(ld_data), .load_count(ld_cnt), .abort(abort),
    .x(x1), .x_valid(xv1), .busy(busy1), .done(done1)
  );

  seqgen_tx #(.WIDTH(8), .REPEAT_W(4), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(rdy0),
    .load_data(ld_data), .load_count(ld_cnt), .abort(abort),
    .x(x0), .x_valid(xv0), .busy(busy0), .done(done0)
  );

  // Detector for the pattern 1,0,1 fed straight from x.
  logic [2:0] win;
  logic       z;
  always @(posedge clk or posedge rst) begin
    if (rst) win <= 3'b000;
    else     win <= {win[1:0], x1};
  end
  assign z = (win == 3'b101);

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  count;
    bit          g0;
    int          len;
    logic [31:0] ex;
    logic [31:0] ev;
    string       name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {x, x_valid, busy, done, load_ready}
  function automatic logic [4:0] obs(input bit g0);
    return g0 ? {x0, xv0, busy0, done0, rdy0} : {x1, xv1, busy1, done1, rdy1};
  endfunction

  // Called at a negedge; returns at the negedge of cycle 1 after accept.
  task automatic start(input bit g0, input logic [7:0] d, input logic [3:0] c);
    ld_data = d;
    ld_cnt  = c;
    if (g0) lv0 = 1'b1;
    else    lv1 = 1'b1;
    @(negedge clk);
    lv0 = 1'b0;
    lv1 = 1'b0;
  endtask

  task automatic run_stream(input bit g0, input logic [31:0] ex, input logic [31:0] ev,
                            input int len, input string name);
    for (int k = 0; k < len; k++) begin
      check($sformatf("%s cyc%0d", name, k + 1), {27'd0, obs(g0)},
            {27'd0, ex[len-1-k], ev[len-1-k], 1'b1, 1'b0, 1'b0});
      @(negedge clk);
    end
    check({name, " done"}, {27'd0, obs(g0)}, 32'h03);
    @(negedge clk);
    check({name, " done-pulse"}, {27'd0, obs(g0)}, 32'h01);
  endtask

  logic [7:0]  pat;
  logic [31:0] mask;

  initial begin
    rst = 1'b1; lv1 = 1'b0; lv0 = 1'b0; ld_data = '0; ld_cnt = '0; abort = 1'b0;

    vecs[0] = '{8'hA5, 4'd0, 1'b0, 8,  32'hA5,   32'hFF,   "A5x1"};
    vecs[1] = '{8'h96, 4'd2, 1'b0, 26, 32'b10010110_0_10010110_0_10010110,
                                       32'b11111111_0_11111111_0_11111111, "96x3gap"};
    vecs[2] = '{8'hF0, 4'd1, 1'b1, 16, 32'hF0F0, 32'hFFFF, "F0x2nogap"};
    vecs[3] = '{8'h3C, 4'd0, 1'b1, 8,  32'h3C,   32'hFF,   "3Cx1nogap"};
    vecs[4] = '{8'h81, 4'd1, 1'b0, 17, 32'b10000001_0_10000001,
                                       32'b11111111_0_11111111, "81x2gap"};

    #1;
    check("reset gap1", {27'd0, obs(1'b0)}, 32'h01);
    check("reset gap0", {27'd0, obs(1'b1)}, 32'h01);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      start(vecs[i].g0, vecs[i].data, vecs[i].count);
      run_stream(vecs[i].g0, vecs[i].ex, vecs[i].ev, vecs[i].len, vecs[i].name);
      @(negedge clk);
    end

    // Load held while busy must not disturb the stream; load on done cycle.
    pat = 8'hA5;
    start(1'b0, pat, 4'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        ld_data = 8'hFF;
        lv1     = 1'b1;
      end
      check($sformatf("busyload cyc%0d", k + 1), {27'd0, obs(1'b0)},
            {27'd0, pat[7-k], 1'b1, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
    end
    check("busyload done", {27'd0, obs(1'b0)}, 32'h03);
    ld_data = 8'h5A;
    ld_cnt  = 4'd0;
    @(negedge clk);
    lv1 = 1'b0;
    run_stream(1'b0, 32'h5A, 32'hFF, 8, "ondone5A");
    @(negedge clk);

    // Abort during the third bit.
    start(1'b0, 8'hA5, 4'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort cyc%0d", k + 1), {27'd0, obs(1'b0)},
            {27'd0, pat[7-k], 1'b1, 1'b1, 1'b0, 1'b0});
      if (k == 2) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort idle", {27'd0, obs(1'b0)}, 32'h01);
    @(negedge clk);
    check("abort no-done", {27'd0, obs(1'b0)}, 32'h01);
    start(1'b0, 8'h3C, 4'd0);
    run_stream(1'b0, 32'h3C, 32'hFF, 8, "post-abort3C");
    @(negedge clk);

    // Asynchronous reset during bit 5.
    start(1'b0, 8'hA5, 4'd0);
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("pre-reset bit5", {27'd0, obs(1'b0)}, 32'h0C);
    #2 rst = 1'b1;
    #1 check("async reset", {27'd0, obs(1'b0)}, 32'h01);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset 1", {27'd0, obs(1'b0)}, 32'h01);
    @(negedge clk);
    check("post-reset 2", {27'd0, obs(1'b0)}, 32'h01);
    @(negedge clk);

    // Loopback into the 101 detector: hits expected in cycles 4 and 9.
    mask = '0;
    start(1'b0, 8'hA5, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      if (z) mask[k] = 1'b1;
      @(negedge clk);
    end
    check("loopback z positions", mask, 32'h210);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
